// File: rtl/rr_arb_mux.sv
// -----------------------------------------------------------------------------
// rr_arb_mux
//
// Round-robin arbitrated N:1 multiplexer with a registered output stage.
// Each input channel uses a valid/ready handshake; one requesting channel is
// granted per cycle and its data is captured into a single output register,
// which is itself drained through a valid/ready handshake.
//
// Parameters:
//   WIDTH  data width per channel (>= 1)
//   N      number of input channels (>= 2, any value)
//   SELW   channel index width, derived as $clog2(N)
//
// Ports:
//   clk          clock, rising-edge
//   rst_n        asynchronous active-low reset
//   prio_mode_i  1 = fixed priority (lowest index wins), 0 = round-robin
//                (present only when RR_ARB_MUX_STRICT_PRIO_EN is defined)
//   in_valid_i   per-channel request, bit i = channel i
//   in_ready_o   per-channel accept, one-hot or zero
//   in_data_i    channel i data at [i*WIDTH +: WIDTH]
//   out_valid_o  output register holds a valid beat
//   out_ready_i  consumer accepts the beat
//   out_data_o   registered data of the granted channel
//   out_sel_o    registered index of the channel that produced out_data_o
//
// Optional feature macro: RR_ARB_MUX_STRICT_PRIO_EN
// -----------------------------------------------------------------------------
module rr_arb_mux #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef RR_ARB_MUX_STRICT_PRIO_EN
  input  logic                 prio_mode_i,
`endif
  input  logic [N-1:0]         in_valid_i,
  output logic [N-1:0]         in_ready_o,
  input  logic [N*WIDTH-1:0]   in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     out_data_o,
  output logic [SELW-1:0]      out_sel_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  last_grant_q, last_grant_d;

  // ---------------------------------------------------------------------------
  // Unpack channel data into an indexable array
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] chan_data [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign chan_data[gi] = in_data_i[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic             load;
  logic [N-1:0]     grant_vec;
  logic             grant_any;
  logic [SELW-1:0]  grant_idx;
  logic [SELW-1:0]  start_idx;
  logic [SELW:0]    cand;

  // The output stage can accept a new beat when it is empty or being drained.
  assign load = !out_valid_q || out_ready_i;

  always_comb begin
    grant_vec = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;

    // Search begins one past the last winner; explicit wrap because N need
    // not be a power of two.
    if (last_grant_q == SELW'(N - 1)) begin
      start_idx = '0;
    end else begin
      start_idx = last_grant_q + SELW'(1);
    end

`ifdef RR_ARB_MUX_STRICT_PRIO_EN
    if (prio_mode_i) begin
      start_idx = '0;
    end
`endif

    for (int k = 0; k < N; k++) begin
      cand = {1'b0, start_idx} + (SELW+1)'(k);
      if (cand >= (SELW+1)'(N)) begin
        cand = cand - (SELW+1)'(N);
      end
      if (!grant_any && in_valid_i[cand[SELW-1:0]]) begin
        grant_any                = 1'b1;
        grant_vec[cand[SELW-1:0]] = 1'b1;
        grant_idx                = cand[SELW-1:0];
      end
    end
  end

  // Gated by rst_n so no channel sees an accept while the block is held in
  // reset (the registers are cleared, which would otherwise make load=1).
  assign in_ready_o = (load && rst_n) ? grant_vec : '0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;

    if (load) begin
      if (grant_any) begin
        // Transfer: a granted channel is by construction valid.
        out_valid_d  = 1'b1;
        out_data_d   = chan_data[grant_idx];
        out_sel_d    = grant_idx;
        last_grant_d = grant_idx;
      end else begin
        // Drain without refill; data/sel keep their last values.
        out_valid_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      last_grant_q <= SELW'(N - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SELW  = 2;

  localparam logic [WIDTH-1:0] D0 = 32'hAAAA_AAAA;
  localparam logic [WIDTH-1:0] D1 = 32'hBBBB_BBBB;
  localparam logic [WIDTH-1:0] D2 = 32'hCCCC_CCCC;
  localparam logic [WIDTH-1:0] D3 = 32'hDDDD_DDDD;

  logic               clk;
  logic               rst_n;
`ifdef RR_ARB_MUX_STRICT_PRIO_EN
  logic               prio_mode;
`endif
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;

  int n_cmp;
  int n_err;

  rr_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef RR_ARB_MUX_STRICT_PRIO_EN
    .prio_mode_i (prio_mode),
`endif
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_sel_o   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]     v;
    logic             r;
    logic [N-1:0]     exp_rdy;
    logic             exp_ov;
    logic [SELW-1:0]  exp_sel;
    logic [WIDTH-1:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [N-1:0] v, input logic r, input logic [N-1:0] er,
                     input logic eov, input logic [SELW-1:0] esel, input logic [WIDTH-1:0] ed);
    vec_t t;
    t.v = v; t.r = r; t.exp_rdy = er; t.exp_ov = eov; t.exp_sel = esel; t.exp_data = ed;
    vecs.push_back(t);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data   = {D3, D2, D1, D0};
`ifdef RR_ARB_MUX_STRICT_PRIO_EN
    prio_mode = 1'b0;
`endif

    // Vector table: inputs applied just after a rising edge; in_ready checked
    // before the next edge, registered outputs checked after it.
    // Fairness from reset (pointer at 3 -> channel 0 first).
    add(4'b1111, 1, 4'b0001, 1, 0, D0);
    add(4'b1111, 1, 4'b0010, 1, 1, D1);
    add(4'b1111, 1, 4'b0100, 1, 2, D2);
    add(4'b1111, 1, 4'b1000, 1, 3, D3);
    add(4'b1111, 1, 4'b0001, 1, 0, D0);
    add(4'b1111, 1, 4'b0010, 1, 1, D1);
    add(4'b1111, 1, 4'b0100, 1, 2, D2);
    add(4'b1111, 1, 4'b1000, 1, 3, D3);
    // Single channel 2.
    add(4'b0100, 1, 4'b0100, 1, 2, D2);
    // Idle: beat drained, data/sel held.
    add(4'b0000, 1, 4'b0000, 0, 2, D2);
    // Skip/wrap: get last=3, then lone ch1, then 3 before 0, then 0.
    add(4'b1000, 1, 4'b1000, 1, 3, D3);
    add(4'b0010, 1, 4'b0010, 1, 1, D1);
    add(4'b1001, 1, 4'b1000, 1, 3, D3);
    add(4'b1001, 1, 4'b0001, 1, 0, D0);
    // Backpressure: ch1 beat held for 3 cycles, then ch2 on the release edge.
    add(4'b1111, 1, 4'b0010, 1, 1, D1);
    add(4'b1111, 0, 4'b0000, 1, 1, D1);
    add(4'b1111, 0, 4'b0000, 1, 1, D1);
    add(4'b1111, 0, 4'b0000, 1, 1, D1);
    add(4'b1111, 1, 4'b0100, 1, 2, D2);

    // Reset held with all channels requesting.
    #12;
    $display("reset hold: ov=%0b sel=%0d data=%h rdy=%b", out_valid, out_sel, out_data, in_ready);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data,  '0);
    check("rst_out_sel",   out_sel,   '0);
    check("rst_in_ready",  in_ready,  '0);
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid  = vecs[i].v;
      out_ready = vecs[i].r;
      #1;
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].exp_rdy);
      @(posedge clk); #1;
      $display("vec %0d: v=%b r=%0b rdy=%b -> ov=%0b sel=%0d data=%h",
               i, vecs[i].v, vecs[i].r, in_ready, out_valid, out_sel, out_data);
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].exp_ov);
      check($sformatf("v%0d_out_sel", i),   out_sel,   vecs[i].exp_sel);
      check($sformatf("v%0d_out_data", i),  out_data,  vecs[i].exp_data);
    end

    // Asynchronous reset mid-stream: outputs clear without a clock edge.
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: ov=%0b sel=%0d data=%h rdy=%b", out_valid, out_sel, out_data, in_ready);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data",  out_data,  '0);
    check("arst_out_sel",   out_sel,   '0);
    check("arst_in_ready",  in_ready,  '0);
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Pointer back to N-1: channel 0 wins first.
    in_valid = 4'b1111;
    #1;
    check("post_rst_in_ready", in_ready, 4'b0001);
    @(posedge clk); #1;
    $display("post reset: ov=%0b sel=%0d data=%h", out_valid, out_sel, out_data);
    check("post_rst_out_sel",  out_sel,  2'd0);
    check("post_rst_out_data", out_data, D0);

`ifdef RR_ARB_MUX_STRICT_PRIO_EN
    // Fixed priority: channel 0 every beat, then round-robin resumes after 0.
    prio_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      $display("prio beat %0d: sel=%0d data=%h", i, out_sel, out_data);
      check($sformatf("prio%0d_out_sel", i), out_sel, 2'd0);
      check($sformatf("prio%0d_out_data", i), out_data, D0);
    end
    prio_mode = 1'b0;
    @(posedge clk); #1;
    $display("rr resume: sel=%0d data=%h", out_sel, out_data);
    check("rr_resume_out_sel", out_sel, 2'd1);
    check("rr_resume_out_data", out_data, D1);
`endif

    in_valid = '0;
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel, WIDTH-bit arbitrated multiplexer; successor to the fixed 4:1 32-bit combinational mux.
- Each input channel has a valid/ready handshake. A round-robin arbiter picks one requesting channel per cycle.
- The winner's data is registered into a single output stage with its own valid/ready handshake.
- Sits between multiple producers and one shared consumer (bus, FIFO, execution port).

Parameters:
- WIDTH, 32, data width per channel in bits (>=1).
- N, 4, number of input channels (>=2; need not be a power of two).
- SELW, $clog2(N), width of the channel index. Derived; not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-channel request; bit i belongs to channel i.
- in_ready  output  N  per-channel accept; one-hot or zero.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  output register holds a valid beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  WIDTH  registered data of the granted channel.
- out_sel  output  SELW  registered index of the channel that produced out_data.

Behaviour:
- Reset (async assert, sync-safe release):
  - out_valid=0, out_data=0, out_sel=0.
  - Internal last_grant=N-1, so channel 0 has first priority after reset.
- load = !out_valid || out_ready. The output stage can take a new beat this cycle.
- Arbitration (combinational):
  - Search in_valid starting at index (last_grant+1) mod N, wrapping to 0 after N-1.
  - The first set bit wins.
  - With no valid inputs there is no grant.
- in_ready[i] = load && grant[i]. At most one bit set. All zero when load=0 or no requests.
- A transfer on channel i occurs when in_valid[i] && in_ready[i]. On that edge:
  - out_data <= channel i data, out_sel <= i, out_valid <= 1, last_grant <= i.
- If load=1 and no transfer occurs: out_valid <= 0. out_data and out_sel hold their old values.
- If load=0 (out_valid && !out_ready): out_valid, out_data and out_sel are held stable. No input is accepted and last_grant is unchanged.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat per cycle when out_ready is held high (pass-through; no bubble).
- last_grant changes only on an actual transfer. A request withdrawn without a transfer does not advance the pointer.
- Fairness: with all N channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0 with no channel starved. Each channel is served within N transfers.
- Single requester: it is granted every load cycle regardless of the pointer.
- Simultaneous events: a new beat loads on the same edge the consumer takes the old one (out_ready=1, out_valid=1).
- Reset mid-operation: any held beat is discarded, outputs return to reset values, and the pointer returns to N-1.
- Combinational paths: in_ready depends on in_valid and out_ready. in_valid must not depend on in_ready, per the standard valid/ready rule.

Optional Feature:
- Macro: RR_ARB_MUX_STRICT_PRIO_EN.
- Defined:
  - Adds input port prio_mode (1 bit).
  - When prio_mode=1, arbitration is fixed priority: lowest-index valid channel wins, and last_grant is still updated on transfer.
  - When prio_mode=0, round-robin as above.
  - Switching prio_mode mid-stream takes effect on the next arbitration with no other side effects.
- Not defined: no prio_mode port; round-robin only.

Test Plan (N=4, WIDTH=32, d0=AAAA_AAAA, d1=BBBB_BBBB, d2=CCCC_CCCC, d3=DDDD_DDDD):
- Reset check: hold rst_n=0 with in_valid=4'b1111 -> out_valid=0, out_data=0, out_sel=0, in_ready=0. Assert rst_n=0 asynchronously mid-stream -> outputs clear without a clock edge.
- Single channel: in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_sel=2, out_data=CCCC_CCCC.
- Round-robin fairness: in_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with matching data and one beat per cycle.
- Backpressure: beat from ch1 held with out_ready=0 for 3 cycles while in_valid=4'b1111 -> out_data stays BBBB_BBBB, out_sel=1, in_ready=0. On out_ready=1 the next beat is ch2 on the same edge.
- Skip/wrap: last grant=3, then in_valid=4'b0010 -> ch1 granted. Then in_valid=4'b1001 -> ch3 granted before ch0.
- Strict priority (macro defined): prio_mode=1, in_valid=4'b1111 for 4 cycles -> out_sel=0 every beat. Set prio_mode=0 -> next out_sel=1.
